// File: rtl/cpu_op_arbiter.sv
// ---------------------------------------------------------------------------
// cpu_op_arbiter
//   Arbitrates two requesters onto one shared cpu_main ALU datapath. One
//   operation is in flight at a time. The state machine steps through
//   IDLE -> ISSUE -> WAIT -> RESP. Any stall in WAIT is bounded by a timeout
//   that completes the operation with an error.
//
// Parameters
//   TIMEOUT_CYCLES  maximum number of WAIT cycles before an error completion
//                   (legal range >= 2)
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   reqN_valid / reqN_ready     requester handshake; ready is combinational
//                               and can only be high during an IDLE grant
//   reqN_opcode, reqN_a/b       requester operation and operands
//   rsp_valid / rsp_ready       response handshake
//   rsp_id, rsp_result,
//   rsp_error                   index of the requester, result, timeout flag
//   cpu_opcode, cpu_a/b         registered operation driven to cpu_main
//   cpu_result, cpu_done        completion returned by cpu_main
//   busy                        high in every state except IDLE
// ---------------------------------------------------------------------------
module cpu_op_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_opcode,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_opcode,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_error,
  output logic [7:0]  cpu_opcode,
  output logic [31:0] cpu_a,
  output logic [31:0] cpu_b,
  input  logic [31:0] cpu_result,
  input  logic        cpu_done,
  output logic        busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  // The timer holds (WAIT cycles already spent - 1), so this value marks the
  // last WAIT cycle that is allowed.
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          last_grant;
  logic          cur_id;
  logic          grant;
  logic          grant_id;

  // Round-robin grant decision. It is visible only in IDLE and never while rst is high.
  always_comb begin
    grant = (state == IDLE) && !rst && (req0_valid || req1_valid);
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant;
    end else begin
      grant_id = req1_valid;
    end
    req0_ready = grant && (grant_id == 1'b0);
    req1_ready = grant && (grant_id == 1'b1);
  end

  assign busy = (state != IDLE);

  // Main sequencer: captures the operation, tracks completion or timeout, and holds the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      last_grant <= 1'b1;
      cur_id     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= 32'd0;
      rsp_error  <= 1'b0;
      cpu_opcode <= 8'd0;
      cpu_a      <= 32'd0;
      cpu_b      <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            cpu_opcode <= grant_id ? req1_opcode : req0_opcode;
            cpu_a      <= grant_id ? req1_a : req0_a;
            cpu_b      <= grant_id ? req1_b : req0_b;
            cur_id     <= grant_id;
            last_grant <= grant_id;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // Completion is checked before timeout, so done wins a tie on the last cycle.
          if (cpu_done) begin
            rsp_result <= cpu_result;
            rsp_error  <= 1'b0;
            rsp_id     <= cur_id;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else if (timer == TIMER_LAST) begin
            rsp_result <= 32'd0;
            rsp_error  <= 1'b1;
            rsp_id     <= cur_id;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else begin
            timer <= timer + {{(TW-1){1'b0}}, 1'b1};
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
